// File: rtl/timer_phase_sequencer_pkg.sv
// Shared definitions for the start_clock/clock_done timer handshake:
// sequencer state encoding and the start_clock levels seen by the timer.
package timer_phase_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_RUN  = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } seq_state_t;

    // The timer runs while start_clock is high and clears after one low cycle.
    localparam logic TIMER_START_ON  = 1'b1;
    localparam logic TIMER_START_OFF = 1'b0;

    function automatic logic is_busy(input seq_state_t s);
        return (s == ST_ARM) || (s == ST_RUN) || (s == ST_GAP);
    endfunction

endpackage

// File: rtl/timer_phase_sequencer_wdog_counter.sv
// Watchdog for the RUN state: counts enabled cycles and flags when the
// count reaches WDOG_MAX; saturates there until cleared.
module timer_phase_sequencer_wdog_counter #(
    parameter int                WDOG_W   = 28,
    parameter logic [WDOG_W-1:0] WDOG_MAX = {WDOG_W{1'b1}}
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [WDOG_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + WDOG_W'(1);
        end
    end

    assign o_expired = (r_count == WDOG_MAX);

endmodule

// File: rtl/timer_phase_sequencer.sv
// Runs a programmable number of back-to-back timed phases on one timer,
// re-arming it between phases and flagging a timer that never answers.
module timer_phase_sequencer
    import timer_phase_sequencer_pkg::*;
#(
    parameter int                PHASE_W  = 4,
    parameter int                WDOG_W   = 28,
    parameter logic [WDOG_W-1:0] WDOG_MAX = {WDOG_W{1'b1}}
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_go,
    input  logic               i_abort,
    input  logic [PHASE_W-1:0] i_num_phases,
    input  logic               i_clock_done,
    output logic               o_start_clock,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_phase_tick,
    output logic               o_busy,
    output logic               o_seq_done,
    output logic               o_timeout_err
);

    seq_state_t         r_state;
    logic [PHASE_W-1:0] r_count;
    logic [PHASE_W-1:0] r_phase;
    logic               r_first;
    logic               r_start_clock;
    logic               r_phase_tick;
    logic               r_busy;
    logic               r_seq_done;
    logic               r_timeout_err;

    seq_state_t         w_next_state;
    logic [PHASE_W-1:0] w_next_count;
    logic [PHASE_W-1:0] w_next_phase;
    logic               w_next_first;
    logic               w_next_tick;
    logic               w_next_done;
    logic               w_next_err;
    logic               w_last;
    logic               w_wdog_expired;

    timer_phase_sequencer_wdog_counter #(
        .WDOG_W   (WDOG_W),
        .WDOG_MAX (WDOG_MAX)
    ) u_wdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (r_state != ST_RUN),
        .i_enable  (r_state == ST_RUN),
        .o_expired (w_wdog_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_phase       <= '0;
            r_first       <= 1'b0;
            r_start_clock <= TIMER_START_OFF;
            r_phase_tick  <= 1'b0;
            r_busy        <= 1'b0;
            r_seq_done    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_count       <= w_next_count;
            r_phase       <= w_next_phase;
            r_first       <= w_next_first;
            r_start_clock <= (w_next_state == ST_RUN) ? TIMER_START_ON : TIMER_START_OFF;
            r_phase_tick  <= w_next_tick;
            r_busy        <= is_busy(w_next_state);
            r_seq_done    <= w_next_done;
            r_timeout_err <= w_next_err;
        end
    end

    // r_first masks the stale clock_done level in the first RUN cycle after ARM/GAP.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_next_phase = r_phase;
        w_next_first = 1'b0;
        w_next_tick  = 1'b0;
        w_next_done  = 1'b0;
        w_next_err   = r_timeout_err;
        w_last       = (r_phase == (r_count - PHASE_W'(1)));

        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (i_go) begin
                    w_next_err = 1'b0;
                    if (i_num_phases != '0) begin
                        w_next_state = ST_ARM;
                        w_next_count = i_num_phases;
                        w_next_phase = '0;
                    end else begin
                        w_next_state = ST_IDLE;
                        w_next_done  = 1'b1;
                    end
                end
            end
            ST_ARM: begin
                if (i_abort) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RUN;
                    w_next_first = 1'b1;
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    w_next_state = ST_IDLE;
                end else if (!r_first && i_clock_done) begin
                    w_next_state = ST_GAP;
                    w_next_tick  = 1'b1;
                    w_next_done  = w_last;
                end else if (w_wdog_expired) begin
                    w_next_state = ST_ERR;
                    w_next_err   = 1'b1;
                end
            end
            ST_GAP: begin
                if (i_abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_last) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RUN;
                    w_next_phase = r_phase + PHASE_W'(1);
                    w_next_first = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign o_start_clock = r_start_clock;
    assign o_phase       = r_phase;
    assign o_phase_tick  = r_phase_tick;
    assign o_busy        = r_busy;
    assign o_seq_done    = r_seq_done;
    assign o_timeout_err = r_timeout_err;

endmodule
